multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 35 +++
 rtl/multicycle_controller_output_decode.sv | 23 ++
 rtl/multicycle_controller.sv | 70 +++++++
 tb/tb_multicycle_controller.sv | 131 +++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: state codes, instruction classes and control strobe bundle
package multicycle_controller_pkg;
   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_RST = 3'd7
   } state_e;
   typedef enum logic [2:0] {
      C_RTYPE  = 3'd0,
      C_LOAD   = 3'd1,
      C_STORE  = 3'd2,
      C_BRANCH = 3'd3,
      C_JUMP   = 3'd4,
      C_OUTPUT = 3'd5,
      C_NOP    = 3'd6
   } class_e;
   localparam logic [3:0] OP_LHI = 4'd9;
   typedef struct packed {
      class_e cls;
      logic   link;
   } iclass_t;
   typedef struct packed {
      logic i_mem_req;
      logic ir_write;
      logic pc_write;
      logic pc_write_cond;
      logic d_mem_read;
      logic d_mem_write;
      logic reg_write;
      logic output_en;
   } ctrl_t;
endpackage

// File: rtl/multicycle_controller_output_decode.sv
// mc_output_decode: combinational control strobes from state and registered class
module mc_output_decode
   import multicycle_controller_pkg::*;
(
   input  state_e     state,
   input  iclass_t    cls,
   input  logic       i_mem_ready,
   output ctrl_t      ctrl
);
   logic fetch_done;
   assign fetch_done = state == S_IF && i_mem_ready;
   always_comb begin
      ctrl               = '0;
      ctrl.i_mem_req     = state == S_IF;
      ctrl.ir_write      = fetch_done;
      ctrl.pc_write      = fetch_done || (state == S_EX && cls.cls == C_JUMP);
      ctrl.pc_write_cond = state == S_EX && cls.cls == C_BRANCH;
      ctrl.d_mem_read    = state == S_MEM && cls.cls == C_LOAD;
      ctrl.d_mem_write   = state == S_MEM && cls.cls == C_STORE;
      ctrl.reg_write     = state == S_WB;
      ctrl.output_en     = state == S_EX && cls.cls == C_OUTPUT;
   end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: IF/ID/EX/MEM/WB sequencer with class register and retired-instruction counter
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  inst_type,
   input  logic [3:0]  opcode,
   input  logic        link,
   input  logic        i_mem_ready,
   input  logic        d_mem_ready,
   output logic        i_mem_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        d_mem_read,
   output logic        d_mem_write,
   output logic        reg_write,
   output logic        output_en,
   output logic [2:0]  state,
   output logic [15:0] num_inst
);
   state_e      state_q, state_d;
   iclass_t     cls_q, cls_d;
   logic [15:0] num_inst_q, num_inst_d;
   ctrl_t       ctrl;
   logic        to_wb;
   assign to_wb = cls_q.cls == C_RTYPE || (cls_q.cls == C_JUMP && cls_q.link)
                  || (cls_q.cls == C_LOAD && opcode == OP_LHI);
   always_comb begin
      state_d = S_RST;
      cls_d   = cls_q;
      case (state_q)
         S_RST: state_d = S_IF;
         S_IF:  state_d = i_mem_ready ? S_ID : S_IF;
         S_ID: begin
            cls_d.cls  = class_e'(inst_type);
            cls_d.link = link;
            state_d    = class_e'(inst_type) == C_NOP ? S_IF : S_EX;
         end
         S_EX:  state_d = to_wb ? S_WB : (cls_q.cls == C_LOAD || cls_q.cls == C_STORE) ? S_MEM : S_IF;
         S_MEM: state_d = !d_mem_ready ? S_MEM : cls_q.cls == C_LOAD ? S_WB : S_IF;
         S_WB:  state_d = S_IF;
         default: state_d = S_RST;
      endcase
      num_inst_d = num_inst_q + 16'(state_d == S_IF && state_q inside {S_ID, S_EX, S_MEM, S_WB});
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RST;
         cls_q      <= '{cls: C_NOP, link: 1'b0};
         num_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         cls_q      <= cls_d;
         num_inst_q <= num_inst_d;
      end
   end
   mc_output_decode u_decode (
      .state       (state_q),
      .cls         (cls_q),
      .i_mem_ready (i_mem_ready),
      .ctrl        (ctrl)
   );
   // strobes are held low for the whole reset cycle so a pending request never completes
   assign {i_mem_req, ir_write, pc_write, pc_write_cond,
           d_mem_read, d_mem_write, reg_write, output_en} = reset ? '0 : ctrl;
   assign state    = state_q;
   assign num_inst = num_inst_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors, expected records queued and checked by a monitor
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;
   logic        clk = 0;
   logic        reset = 1;
   logic [2:0]  inst_type = 3'd6;
   logic [3:0]  opcode = 0;
   logic        link = 0;
   logic        i_mem_ready = 0;
   logic        d_mem_ready = 0;
   logic        i_mem_req, ir_write, pc_write, pc_write_cond;
   logic        d_mem_read, d_mem_write, reg_write, output_en;
   logic [2:0]  state;
   logic [15:0] num_inst;
   typedef struct {
      logic [2:0]  st;
      logic [7:0]  strb;
      logic [15:0] n;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   localparam logic [2:0] RT = 3'd0, LD = 3'd1, ST = 3'd2, BR = 3'd3, JP = 3'd4, OU = 3'd5, NP = 3'd6;
   localparam logic [7:0] FETCH = 8'hE0, WAITI = 8'h80, PW = 8'h20, PC = 8'h10,
                          DR = 8'h08, DW = 8'h04, RW = 8'h02, OE = 8'h01;
   always #5 clk = ~clk;
   multicycle_controller dut (
      .clk(clk), .reset(reset), .inst_type(inst_type), .opcode(opcode), .link(link),
      .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready),
      .i_mem_req(i_mem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .reg_write(reg_write), .output_en(output_en), .state(state), .num_inst(num_inst)
   );
   task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h want %h", nm, c, act, exp);
      end
   endtask
   always @(negedge clk) begin
      #2;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("state", cyc, 16'(state), 16'(e.st));
         chk("strobes", cyc, 16'({i_mem_req, ir_write, pc_write, pc_write_cond,
                                  d_mem_read, d_mem_write, reg_write, output_en}), 16'(e.strb));
         chk("num_inst", cyc, num_inst, e.n);
         cyc++;
      end
   end
   task automatic step(input logic r, input logic [2:0] it, input logic lk, input logic [3:0] op,
                       input logic im, input logic dm,
                       input logic [2:0] est, input logic [7:0] es, input logic [15:0] en);
      @(negedge clk);
      reset = r; inst_type = it; link = lk; opcode = op; i_mem_ready = im; d_mem_ready = dm;
      q.push_back('{st: est, strb: es, n: en});
   endtask
   initial begin
      step(1, NP, 0, 0, 0, 0, 7, 0, 0);
      step(1, NP, 0, 0, 1, 1, 7, 0, 0);
      step(0, NP, 0, 0, 0, 0, 7, 0, 0);
      // RTYPE with readies high outside their request windows
      step(0, NP, 0, 0, 1, 1, 0, FETCH, 0);
      step(0, RT, 0, 0, 1, 1, 1, 0, 0);
      step(0, NP, 0, 0, 1, 1, 2, 0, 0);
      step(0, NP, 0, 0, 1, 1, 4, RW, 0);
      // LOAD: fetch stalls 3 cycles, data stalls 2 cycles
      for (int i = 0; i < 3; i++) step(0, NP, 0, 0, 0, 1, 0, WAITI, 1);
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 1);
      step(0, LD, 0, 0, 0, 0, 1, 0, 1);
      step(0, NP, 0, 0, 0, 0, 2, 0, 1);
      step(0, NP, 0, 0, 0, 0, 3, DR, 1);
      step(0, NP, 0, 0, 0, 0, 3, DR, 1);
      step(0, NP, 0, 0, 0, 1, 3, DR, 1);
      step(0, NP, 0, 0, 0, 0, 4, RW, 1);
      // LHI skips MEM
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 2);
      step(0, LD, 0, OP_LHI, 0, 0, 1, 0, 2);
      step(0, NP, 0, OP_LHI, 0, 1, 2, 0, 2);
      step(0, NP, 0, OP_LHI, 0, 0, 4, RW, 2);
      // JAL: live link dropped after ID to exercise the class register
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 3);
      step(0, JP, 1, 0, 0, 0, 1, 0, 3);
      step(0, NP, 0, 0, 0, 0, 2, PW, 3);
      step(0, NP, 0, 0, 0, 0, 4, RW, 3);
      // BRANCH then NOP
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 4);
      step(0, BR, 0, 0, 0, 0, 1, 0, 4);
      step(0, NP, 0, 0, 0, 0, 2, PC, 4);
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 5);
      step(0, NP, 0, 0, 0, 0, 1, 0, 5);
      // STORE, OUTPUT, JR
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 6);
      step(0, ST, 0, 0, 0, 0, 1, 0, 6);
      step(0, NP, 0, 0, 0, 0, 2, 0, 6);
      step(0, NP, 0, 0, 0, 1, 3, DW, 6);
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 7);
      step(0, OU, 0, 0, 0, 0, 1, 0, 7);
      step(0, NP, 0, 0, 0, 0, 2, OE, 7);
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 8);
      step(0, JP, 0, 0, 0, 0, 1, 0, 8);
      step(0, NP, 1, 0, 0, 0, 2, PW, 8);
      // reset lands in MEM together with d_mem_ready
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 9);
      step(0, LD, 0, 0, 0, 0, 1, 0, 9);
      step(0, NP, 0, 0, 0, 0, 2, 0, 9);
      step(1, NP, 0, 0, 0, 1, 3, 0, 9);
      step(0, NP, 0, 0, 0, 1, 7, 0, 0);
      // reset lands in IF together with i_mem_ready
      step(1, NP, 0, 0, 1, 0, 0, 0, 0);
      step(0, NP, 0, 0, 0, 0, 7, 0, 0);
      step(0, NP, 0, 0, 0, 0, 0, WAITI, 0);
      // counter wrap: preload to FFFF while stalled in IF, then retire one NOP
      #3 force dut.num_inst_q = 16'hFFFF;
      #1 release dut.num_inst_q;
      step(0, NP, 0, 0, 1, 0, 0, FETCH, 16'hFFFF);
      step(0, NP, 0, 0, 0, 0, 1, 0, 16'hFFFF);
      step(0, NP, 0, 0, 0, 0, 0, WAITI, 16'h0000);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #4;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
